// File: rtl/parameter_define.sv
// Shared pipeline encodings and the NOP control bundle for the ID/EX boundary.
package parameter_define;

  typedef enum logic [1:0] {MNONE = 2'b00, READ = 2'b01, WRITE = 2'b10} mem_rw_e;
  typedef enum logic [2:0] {BNONE = 3'b000, BEQ = 3'b001, BNE = 3'b010, BLT = 3'b011,
                            BGE = 3'b100, BLTU = 3'b101, BGEU = 3'b110} br_e;
  typedef enum logic [4:0] {ADD = 5'd0, SUB = 5'd1, AND_OP = 5'd2, OR_OP = 5'd3,
                            XOR_OP = 5'd4, SLL = 5'd5, SRL = 5'd6, SRA = 5'd7} alu_e;
  typedef enum logic [2:0] {BYTE = 3'b000, HALF = 3'b001, WORD = 3'b010,
                            BYTEU = 3'b100, HALFU = 3'b101} mem_size_e;

  typedef struct packed {
    alu_e       alucrl;
    logic       jump;
    logic       RegWrite;
    mem_rw_e    MemReWr;
    mem_size_e  MemWHB;
    logic       alu_res_pc4;
    br_e        Branctrl;
    logic [1:0] alu_val1_type;
    logic [1:0] alu_val2_type;
    logic [2:0] Imm_Sel;
    logic       CSR_sel;
  } ctrl_t;

  localparam ctrl_t NOP_CTRL = '{
    alucrl: ADD, jump: 1'b0, RegWrite: 1'b0, MemReWr: MNONE, MemWHB: WORD,
    alu_res_pc4: 1'b0, Branctrl: BNONE, alu_val1_type: 2'b00, alu_val2_type: 2'b00,
    Imm_Sel: 3'b000, CSR_sel: 1'b0
  };

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard: the load in EX writes a register the ID instruction reads.
module hazard_detect
  import parameter_define::*;
(
  input  logic       ex_valid_i,
  input  mem_rw_e    ex_mem_rw_i,
  input  logic [4:0] ex_rd_i,
  input  logic       id_valid_i,
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  output logic       hazard_o
);

  assign hazard_o = ex_valid_i && (ex_mem_rw_i == READ) && (ex_rd_i != 5'd0) && id_valid_i &&
                    ((ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i));

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with flush, EX stall, load-use bubble insertion and
// bubble/flush performance counters.
module id_ex_reg
  import parameter_define::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic [4:0]      id_alucrl,
  input  logic            id_jump,
  input  logic            id_RegWrite,
  input  logic [1:0]      id_MemReWr,
  input  logic [2:0]      id_MemWHB,
  input  logic            id_alu_res_pc4,
  input  logic [2:0]      id_Branctrl,
  input  logic [1:0]      id_alu_val1_type,
  input  logic [1:0]      id_alu_val2_type,
  input  logic [2:0]      id_Imm_Sel,
  input  logic            id_CSR_sel,
  input  logic            flush,
  input  logic            ex_stall,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic [4:0]      ex_alucrl,
  output logic            ex_jump,
  output logic            ex_RegWrite,
  output logic [1:0]      ex_MemReWr,
  output logic [2:0]      ex_MemWHB,
  output logic            ex_alu_res_pc4,
  output logic [2:0]      ex_Branctrl,
  output logic [1:0]      ex_alu_val1_type,
  output logic [1:0]      ex_alu_val2_type,
  output logic [2:0]      ex_Imm_Sel,
  output logic            ex_CSR_sel,
  output logic            id_stall,
  output logic [31:0]     bubble_cnt,
  output logic [31:0]     flush_cnt
);

  logic            valid_q, valid_d;
  logic [XLEN-1:0] pc_q, pc_d, rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d, imm_q, imm_d;
  logic [4:0]      rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  ctrl_t           ctrl_q, ctrl_d, id_ctrl;
  logic [31:0]     bubble_q, bubble_d, flush_q, flush_d;
  logic            hazard;

  assign id_ctrl = '{
    alucrl: alu_e'(id_alucrl), jump: id_jump, RegWrite: id_RegWrite,
    MemReWr: mem_rw_e'(id_MemReWr), MemWHB: mem_size_e'(id_MemWHB),
    alu_res_pc4: id_alu_res_pc4, Branctrl: br_e'(id_Branctrl),
    alu_val1_type: id_alu_val1_type, alu_val2_type: id_alu_val2_type,
    Imm_Sel: id_Imm_Sel, CSR_sel: id_CSR_sel
  };

  hazard_detect u_hazard_detect (
    .ex_valid_i  (valid_q),
    .ex_mem_rw_i (ctrl_q.MemReWr),
    .ex_rd_i     (rd_q),
    .id_valid_i  (id_valid),
    .id_rs1_i    (id_rs1),
    .id_rs2_i    (id_rs2),
    .hazard_o    (hazard)
  );

  // rst gate keeps id_stall low while an ex_stall is still asserted during reset
  assign id_stall = !rst && !flush && (ex_stall || hazard);

  always_comb begin
    valid_d    = valid_q;
    pc_d       = pc_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    imm_d      = imm_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rd_d       = rd_q;
    ctrl_d     = ctrl_q;
    bubble_d   = bubble_q;
    flush_d    = flush_q;
    if (flush || (!ex_stall && (hazard || !id_valid))) begin
      valid_d    = 1'b0;
      pc_d       = '0;
      rs1_data_d = '0;
      rs2_data_d = '0;
      imm_d      = '0;
      rs1_d      = '0;
      rs2_d      = '0;
      rd_d       = '0;
      ctrl_d     = NOP_CTRL;
      if (flush)       flush_d  = flush_q + 32'd1;
      else if (hazard) bubble_d = bubble_q + 32'd1;
    end else if (!ex_stall) begin
      valid_d    = 1'b1;
      pc_d       = id_pc;
      rs1_data_d = id_rs1_data;
      rs2_data_d = id_rs2_data;
      imm_d      = id_imm;
      rs1_d      = id_rs1;
      rs2_d      = id_rs2;
      rd_d       = id_rd;
      ctrl_d     = id_ctrl;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      ctrl_q     <= NOP_CTRL;
      bubble_q   <= '0;
      flush_q    <= '0;
    end else begin
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      ctrl_q     <= ctrl_d;
      bubble_q   <= bubble_d;
      flush_q    <= flush_d;
    end
  end

  assign ex_valid         = valid_q;
  assign ex_pc            = pc_q;
  assign ex_rs1_data      = rs1_data_q;
  assign ex_rs2_data      = rs2_data_q;
  assign ex_imm           = imm_q;
  assign ex_rs1           = rs1_q;
  assign ex_rs2           = rs2_q;
  assign ex_rd            = rd_q;
  assign ex_alucrl        = ctrl_q.alucrl;
  assign ex_jump          = ctrl_q.jump;
  assign ex_RegWrite      = ctrl_q.RegWrite;
  assign ex_MemReWr       = ctrl_q.MemReWr;
  assign ex_MemWHB        = ctrl_q.MemWHB;
  assign ex_alu_res_pc4   = ctrl_q.alu_res_pc4;
  assign ex_Branctrl      = ctrl_q.Branctrl;
  assign ex_alu_val1_type = ctrl_q.alu_val1_type;
  assign ex_alu_val2_type = ctrl_q.alu_val2_type;
  assign ex_Imm_Sel       = ctrl_q.Imm_Sel;
  assign ex_CSR_sel       = ctrl_q.CSR_sel;
  assign bubble_cnt       = bubble_q;
  assign flush_cnt        = flush_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// Randomized bench for id_ex_reg against a transaction-level model of the
// ID/EX boundary (one instruction slot plus two event counters).
module tb_id_ex_reg;
  import parameter_define::*;

  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst;
  logic id_valid, flush, ex_stall;
  logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0] id_rs1, id_rs2, id_rd, id_alucrl;
  logic id_jump, id_RegWrite, id_alu_res_pc4, id_CSR_sel;
  logic [1:0] id_MemReWr, id_alu_val1_type, id_alu_val2_type;
  logic [2:0] id_MemWHB, id_Branctrl, id_Imm_Sel;

  logic ex_valid;
  logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0] ex_rs1, ex_rs2, ex_rd, ex_alucrl;
  logic ex_jump, ex_RegWrite, ex_alu_res_pc4, ex_CSR_sel;
  logic [1:0] ex_MemReWr, ex_alu_val1_type, ex_alu_val2_type;
  logic [2:0] ex_MemWHB, ex_Branctrl, ex_Imm_Sel;
  logic id_stall;
  logic [31:0] bubble_cnt, flush_cnt;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  id_ex_reg #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_alucrl(id_alucrl),
    .id_jump(id_jump), .id_RegWrite(id_RegWrite), .id_MemReWr(id_MemReWr),
    .id_MemWHB(id_MemWHB), .id_alu_res_pc4(id_alu_res_pc4), .id_Branctrl(id_Branctrl),
    .id_alu_val1_type(id_alu_val1_type), .id_alu_val2_type(id_alu_val2_type),
    .id_Imm_Sel(id_Imm_Sel), .id_CSR_sel(id_CSR_sel), .flush(flush), .ex_stall(ex_stall),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_alucrl(ex_alucrl),
    .ex_jump(ex_jump), .ex_RegWrite(ex_RegWrite), .ex_MemReWr(ex_MemReWr),
    .ex_MemWHB(ex_MemWHB), .ex_alu_res_pc4(ex_alu_res_pc4), .ex_Branctrl(ex_Branctrl),
    .ex_alu_val1_type(ex_alu_val1_type), .ex_alu_val2_type(ex_alu_val2_type),
    .ex_Imm_Sel(ex_Imm_Sel), .ex_CSR_sel(ex_CSR_sel), .id_stall(id_stall),
    .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
  );

  typedef struct {
    logic v;
    logic [XLEN-1:0] pc, a, b, imm;
    logic [4:0] rs1, rs2, rd, alu;
    logic j, rw, p4, csr;
    logic [1:0] mrw, t1, t2;
    logic [2:0] whb, br, isel;
  } slot_t;

  slot_t m;
  logic [31:0] m_bub, m_fl;

  function automatic slot_t nop_slot();
    slot_t s;
    s = '{v: 1'b0, pc: '0, a: '0, b: '0, imm: '0, rs1: '0, rs2: '0, rd: '0, alu: '0,
          j: 1'b0, rw: 1'b0, p4: 1'b0, csr: 1'b0, mrw: '0, t1: '0, t2: '0, whb: '0,
          br: '0, isel: '0};
    s.alu = ADD;
    s.mrw = MNONE;
    s.br  = BNONE;
    s.whb = WORD;
    return s;
  endfunction

  function automatic slot_t id_slot();
    slot_t s;
    s = '{v: 1'b1, pc: id_pc, a: id_rs1_data, b: id_rs2_data, imm: id_imm, rs1: id_rs1,
          rs2: id_rs2, rd: id_rd, alu: id_alucrl, j: id_jump, rw: id_RegWrite,
          p4: id_alu_res_pc4, csr: id_CSR_sel, mrw: id_MemReWr, t1: id_alu_val1_type,
          t2: id_alu_val2_type, whb: id_MemWHB, br: id_Branctrl, isel: id_Imm_Sel};
    return s;
  endfunction

  function automatic logic [191:0] pack_slot(slot_t s);
    return {24'd0, s.v, s.pc, s.a, s.b, s.imm, s.rs1, s.rs2, s.rd, s.alu, s.j, s.rw,
            s.mrw, s.whb, s.p4, s.br, s.t1, s.t2, s.isel, s.csr};
  endfunction

  function automatic logic [191:0] dut_slot();
    return {24'd0, ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd,
            ex_alucrl, ex_jump, ex_RegWrite, ex_MemReWr, ex_MemWHB, ex_alu_res_pc4,
            ex_Branctrl, ex_alu_val1_type, ex_alu_val2_type, ex_Imm_Sel, ex_CSR_sel};
  endfunction

  // A load in EX whose destination the ID instruction reads.
  function automatic logic load_use();
    return m.v && m.mrw == READ && m.rd != 5'd0 && id_valid &&
           (m.rd == id_rs1 || m.rd == id_rs2);
  endfunction

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".ex"}, dut_slot(), pack_slot(m));
    check({tag, ".bubble_cnt"}, {160'd0, bubble_cnt}, {160'd0, m_bub});
    check({tag, ".flush_cnt"}, {160'd0, flush_cnt}, {160'd0, m_fl});
  endtask

  task automatic model_edge();
    if (flush) begin
      m = nop_slot();
      m_fl++;
    end else if (ex_stall) begin
      m = m;
    end else if (load_use()) begin
      m = nop_slot();
      m_bub++;
    end else if (id_valid) begin
      m = id_slot();
    end else begin
      m = nop_slot();
    end
  endtask

  // Inputs are set at a falling edge; id_stall is checked, then one rising edge.
  task automatic cycle(input string tag);
    #1 check({tag, ".id_stall"}, {191'd0, id_stall}, {191'd0, !flush && (ex_stall || load_use())});
    @(posedge clk);
    model_edge();
    #1 check_state(tag);
    @(negedge clk);
  endtask

  task automatic set_instr(input logic [1:0] mrw, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [4:0] rd);
    id_valid = 1'b1;
    id_pc = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
    id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_alucrl = ADD; id_jump = 1'b0; id_RegWrite = (mrw != WRITE);
    id_MemReWr = mrw; id_MemWHB = WORD; id_alu_res_pc4 = 1'b0; id_Branctrl = BNONE;
    id_alu_val1_type = 2'd1; id_alu_val2_type = 2'd2; id_Imm_Sel = 3'd1; id_CSR_sel = 1'b0;
    flush = 1'b0; ex_stall = 1'b0;
  endtask

  task automatic rnd_inputs();
    id_valid = ($urandom_range(0, 9) < 8);
    id_pc = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
    id_rs1 = 5'($urandom_range(0, 6)); id_rs2 = 5'($urandom_range(0, 6));
    id_rd = 5'($urandom_range(0, 6)); id_alucrl = 5'($urandom);
    id_jump = 1'($urandom); id_RegWrite = 1'($urandom);
    id_MemReWr = ($urandom_range(0, 2) == 0) ? 2'($urandom) : READ;
    id_MemWHB = 3'($urandom); id_alu_res_pc4 = 1'($urandom); id_Branctrl = 3'($urandom);
    id_alu_val1_type = 2'($urandom); id_alu_val2_type = 2'($urandom);
    id_Imm_Sel = 3'($urandom); id_CSR_sel = 1'($urandom);
    flush = ($urandom_range(0, 9) == 0);
    ex_stall = ($urandom_range(0, 4) == 0);
  endtask

  initial begin
    rst = 1'b1;
    set_instr(MNONE, 5'd0, 5'd0, 5'd0);
    ex_stall = 1'b1;
    m = nop_slot(); m_bub = '0; m_fl = '0;
    #2;
    check_state("reset");
    check("reset.id_stall", {191'd0, id_stall}, 192'd0);
    @(negedge clk);
    rst = 1'b0;
    ex_stall = 1'b0;

    set_instr(MNONE, 5'd1, 5'd2, 5'd3);
    cycle("add_load");

    set_instr(READ, 5'd1, 5'd2, 5'd5);
    cycle("lw_rd5");
    set_instr(MNONE, 5'd5, 5'd7, 5'd6);
    cycle("lu_bubble");
    cycle("lu_reload");

    set_instr(READ, 5'd1, 5'd2, 5'd0);
    cycle("lw_rd0");
    set_instr(MNONE, 5'd0, 5'd4, 5'd6);
    cycle("rd0_nohaz");

    set_instr(READ, 5'd1, 5'd2, 5'd9);
    cycle("lw_rd9");
    set_instr(MNONE, 5'd3, 5'd9, 5'd6);
    for (int unsigned i = 0; i < 3; i++) begin
      ex_stall = 1'b1;
      cycle("stall_hold");
    end
    ex_stall = 1'b0;
    cycle("stall_release");
    cycle("stall_reload");

    set_instr(READ, 5'd1, 5'd2, 5'd8);
    cycle("lw_rd8");
    set_instr(MNONE, 5'd8, 5'd8, 5'd6);
    flush = 1'b1; ex_stall = 1'b1;
    cycle("flush_all");

    set_instr(READ, 5'd1, 5'd2, 5'd4);
    cycle("lw_rd4");
    set_instr(MNONE, 5'd4, 5'd1, 5'd6);
    ex_stall = 1'b1;
    cycle("pre_rst_stall");
    #1 rst = 1'b1;
    #1;
    m = nop_slot(); m_bub = '0; m_fl = '0;
    check_state("rst_mid");
    check("rst_mid.id_stall", {191'd0, id_stall}, 192'd0);
    rst = 1'b0;
    ex_stall = 1'b0;
    cycle("post_rst_load");

    for (int unsigned i = 0; i < 400; i++) begin
      rnd_inputs();
      cycle("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
